// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and helpers for hazard detection and forwarding
package pipeline_pkg;

    // Width of the register addresses held in the per-stage tracking records.
    localparam int TRACK_AW = 5;

    // x0 is hardwired to zero and never forwarded.
    localparam logic [TRACK_AW-1:0] REG_X0 = '0;

    // EX operand mux select, aligned with the instruction once it sits in EX.
    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,   // register-file value
        FWD_MEM  = 2'b01,   // EX/MEM ALU result
        FWD_WB   = 2'b10,   // MEM/WB writeback data
        FWD_HOLD = 2'b11    // WB-hold register
    } fwd_sel_t;

    // What the hazard logic needs to know about an in-flight instruction.
    typedef struct packed {
        logic                valid;
        logic [TRACK_AW-1:0] rd;
        logic                regwrite;
        logic                is_load;
    } stage_track_t;

    // True when the stage will produce a new value for register r.
    function automatic logic stage_writes(input stage_track_t s, input logic [TRACK_AW-1:0] r);
        return s.valid && s.regwrite && (s.rd == r) && (r != REG_X0);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - combinational operand forwarding select for one source register
//
// Ports:
//   rs        source register read by the DE instruction
//   used      DE instruction actually reads rs
//   ex_stage  tracking record of the instruction currently in EX
//   mem_stage tracking record of the instruction currently in MEM
//   wb_stage  tracking record of the instruction currently in WB
//   sel       select code the operand mux will need once DE moves into EX
module fwd_select
    import pipeline_pkg::*;
(
    input  logic [TRACK_AW-1:0] rs,
    input  logic                used,
    input  stage_track_t        ex_stage,
    input  stage_track_t        mem_stage,
    input  stage_track_t        wb_stage,
    output fwd_sel_t            sel
);

    // The load flag only matters for load-use detection, handled in the top.
    logic unused_load_bits;
    assign unused_load_bits = ex_stage.is_load ^ mem_stage.is_load ^ wb_stage.is_load;

    // Each producer is one stage further along by the time the consumer is
    // in EX, so EX maps to the EX/MEM result, MEM to MEM/WB, WB to the hold
    // register. Priority order makes the closest producer win.
    always_comb begin
        sel = FWD_RF;
        if (used) begin
            if (stage_writes(ex_stage, rs)) begin
                sel = FWD_MEM;
            end else if (stage_writes(mem_stage, rs)) begin
                sel = FWD_WB;
            end else if (stage_writes(wb_stage, rs)) begin
                sel = FWD_HOLD;
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - pipeline hazard detection, forwarding selects and stall counter
//
// Ports:
//   CLK, RST_N           clock and asynchronous active-low reset
//   de_*                 decoded fields of the instruction in DE
//   ex_branch_taken      taken branch/jump resolved in EX
//   stall_if_de          hold PC and IF/DE (combinational)
//   flush_if_de          squash IF/DE (combinational)
//   ex_valid             EX holds a live instruction (registered)
//   fwd_sel_a/fwd_sel_b  EX operand mux selects (registered)
//   stall_count          saturating count of load-use stall cycles
module hazard_fwd_unit
    import pipeline_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 de_valid,
    input  logic [REG_AW-1:0]    de_rs1,
    input  logic [REG_AW-1:0]    de_rs2,
    input  logic                 de_rs1_used,
    input  logic                 de_rs2_used,
    input  logic [REG_AW-1:0]    de_rd,
    input  logic                 de_regwrite,
    input  logic                 de_is_load,
    input  logic                 ex_branch_taken,
    output logic                 stall_if_de,
    output logic                 flush_if_de,
    output logic                 ex_valid,
    output logic [1:0]           fwd_sel_a,
    output logic [1:0]           fwd_sel_b,
    output logic [CNT_WIDTH-1:0] stall_count
);

    stage_track_t ex_q, mem_q, wb_q, hold_q;
    stage_track_t ex_d;
    fwd_sel_t     sel_a_d, sel_b_d;
    logic [1:0]   sel_a_q, sel_b_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic load_use;
    logic take_stall;
    logic bubble;

    // The hold stage is tracked so the record mirrors the datapath, but by the
    // time a consumer could reach it the value is already in the register file.
    logic unused_hold_bits;
    assign unused_hold_bits = ^{hold_q, wb_q.is_load, mem_q.is_load};

    fwd_select u_sel_a (
        .rs        (de_rs1),
        .used      (de_rs1_used),
        .ex_stage  (ex_q),
        .mem_stage (mem_q),
        .wb_stage  (wb_q),
        .sel       (sel_a_d)
    );

    fwd_select u_sel_b (
        .rs        (de_rs2),
        .used      (de_rs2_used),
        .ex_stage  (ex_q),
        .mem_stage (mem_q),
        .wb_stage  (wb_q),
        .sel       (sel_b_d)
    );

    // A load's data is not available from EX/MEM, so a consumer directly
    // behind it must wait one cycle and pick it up from MEM/WB instead.
    assign load_use = de_valid && ex_q.valid && ex_q.is_load &&
                      ((de_rs1_used && stage_writes(ex_q, de_rs1)) ||
                       (de_rs2_used && stage_writes(ex_q, de_rs2)));

    // A taken branch kills the DE instruction, so its hazard is moot.
    assign take_stall = load_use && !ex_branch_taken;

    assign stall_if_de = RST_N && take_stall;
    assign flush_if_de = RST_N && ex_branch_taken;

    assign bubble = !de_valid || load_use || ex_branch_taken;

    always_comb begin
        ex_d = '0;
        if (!bubble) begin
            ex_d.valid    = 1'b1;
            ex_d.rd       = de_rd;
            ex_d.regwrite = de_regwrite;
            ex_d.is_load  = de_is_load;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            hold_q  <= '0;
            sel_a_q <= FWD_RF;
            sel_b_q <= FWD_RF;
            cnt_q   <= '0;
        end else begin
            hold_q  <= wb_q;
            wb_q    <= mem_q;
            mem_q   <= ex_q;
            ex_q    <= ex_d;
            sel_a_q <= bubble ? FWD_RF : sel_a_d;
            sel_b_q <= bubble ? FWD_RF : sel_b_d;
            if (take_stall && (cnt_q != {CNT_WIDTH{1'b1}})) begin
                cnt_q <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign ex_valid    = ex_q.valid;
    assign fwd_sel_a   = sel_a_q;
    assign fwd_sel_b   = sel_b_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - table-driven bench for hazard_fwd_unit
module tb_hazard_fwd_unit;

    logic       CLK;
    logic       RST_N;
    logic       de_valid;
    logic [4:0] de_rs1;
    logic [4:0] de_rs2;
    logic       de_rs1_used;
    logic       de_rs2_used;
    logic [4:0] de_rd;
    logic       de_regwrite;
    logic       de_is_load;
    logic       ex_branch_taken;
    logic       stall_if_de;
    logic       flush_if_de;
    logic       ex_valid;
    logic [1:0] fwd_sel_a;
    logic [1:0] fwd_sel_b;
    logic [1:0] stall_count;

    int checks = 0;
    int errors = 0;

    hazard_fwd_unit #(.REG_AW(5), .CNT_WIDTH(2)) dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .de_valid        (de_valid),
        .de_rs1          (de_rs1),
        .de_rs2          (de_rs2),
        .de_rs1_used     (de_rs1_used),
        .de_rs2_used     (de_rs2_used),
        .de_rd           (de_rd),
        .de_regwrite     (de_regwrite),
        .de_is_load      (de_is_load),
        .ex_branch_taken (ex_branch_taken),
        .stall_if_de     (stall_if_de),
        .flush_if_de     (flush_if_de),
        .ex_valid        (ex_valid),
        .fwd_sel_a       (fwd_sel_a),
        .fwd_sel_b       (fwd_sel_b),
        .stall_count     (stall_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       br;
        int         e_stall;
        int         e_flush;
        int         e_exv;
        int         e_a;
        int         e_b;
        int         e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input int rs1, input logic u1, input int rs2,
                                input logic u2, input int rd, input logic rw, input logic ld,
                                input logic br, input int st, input int fl, input int exv,
                                input int a, input int b, input int cnt);
        vec_t r;
        r.v = v; r.rs1 = 5'(rs1); r.u1 = u1; r.rs2 = 5'(rs2); r.u2 = u2;
        r.rd = 5'(rd); r.rw = rw; r.ld = ld; r.br = br;
        r.e_stall = st; r.e_flush = fl; r.e_exv = exv; r.e_a = a; r.e_b = b; r.e_cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        de_valid        = v.v;
        de_rs1          = v.rs1;
        de_rs1_used     = v.u1;
        de_rs2          = v.rs2;
        de_rs2_used     = v.u2;
        de_rd           = v.rd;
        de_regwrite     = v.rw;
        de_is_load      = v.ld;
        ex_branch_taken = v.br;
    endtask

    // Inputs change 1 time unit after a rising edge; combinational outputs are
    // checked mid-cycle, registered outputs 1 unit after the following edge.
    task automatic apply(input vec_t v, input int idx);
        drive(v);
        #1;
        chk("stall_if_de", idx, int'(stall_if_de), v.e_stall);
        chk("flush_if_de", idx, int'(flush_if_de), v.e_flush);
        @(posedge CLK);
        #1;
        chk("ex_valid", idx, int'(ex_valid), v.e_exv);
        chk("fwd_sel_a", idx, int'(fwd_sel_a), v.e_a);
        chk("fwd_sel_b", idx, int'(fwd_sel_b), v.e_b);
        chk("stall_count", idx, int'(stall_count), v.e_cnt);
    endtask

    initial begin
        int c;
        RST_N = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ex_valid", 0, int'(ex_valid), 0);
        chk("rst_sel_a", 0, int'(fwd_sel_a), 0);
        chk("rst_sel_b", 0, int'(fwd_sel_b), 0);
        chk("rst_count", 0, int'(stall_count), 0);
        chk("rst_stall", 0, int'(stall_if_de), 0);
        chk("rst_flush", 0, int'(flush_if_de), 0);
        ex_branch_taken = 1'b0;
        RST_N = 1'b1;

        //        v rs1 u1 rs2 u2 rd rw ld br  st fl exv a  b  cnt
        tbl.push_back(mk(1,  1, 1,  2, 1,  5, 1, 0, 0, 0, 0, 1, 0, 0, 0)); // add x5
        tbl.push_back(mk(1,  5, 1,  6, 1,  8, 1, 0, 0, 0, 0, 1, 1, 0, 0)); // use x5 back-to-back
        tbl.push_back(mk(1,  0, 0,  0, 0,  7, 1, 0, 0, 0, 0, 1, 0, 0, 0)); // producer x7
        tbl.push_back(mk(1, 10, 1, 11, 1,  9, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 12, 1,  7, 1, 13, 1, 0, 0, 0, 0, 1, 0, 2, 0)); // distance 2
        tbl.push_back(mk(1,  0, 0,  0, 0, 14, 1, 0, 0, 0, 0, 1, 0, 0, 0)); // producer x14
        tbl.push_back(mk(1, 16, 1, 17, 1, 15, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 19, 1, 20, 1, 18, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 21, 1, 14, 1, 30, 1, 0, 0, 0, 0, 1, 0, 3, 0)); // distance 3
        tbl.push_back(mk(1,  0, 0,  0, 0, 22, 1, 0, 0, 0, 0, 1, 0, 0, 0)); // producer x22
        tbl.push_back(mk(1,  0, 0,  0, 0, 23, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1,  0, 0,  0, 0, 24, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1,  0, 0,  0, 0, 25, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 31, 1, 22, 1, 26, 1, 0, 0, 0, 0, 1, 0, 0, 0)); // distance 4
        tbl.push_back(mk(1,  1, 1,  0, 0,  3, 1, 1, 0, 0, 0, 1, 0, 0, 0)); // lw x3
        tbl.push_back(mk(1,  3, 1,  4, 1, 27, 1, 0, 0, 1, 0, 0, 0, 0, 1)); // load-use stall
        tbl.push_back(mk(1,  3, 1,  4, 1, 27, 1, 0, 0, 0, 0, 1, 2, 0, 1)); // resolved from MEM/WB
        tbl.push_back(mk(1,  0, 0,  0, 0,  3, 1, 1, 0, 0, 0, 1, 0, 0, 1)); // lw x3
        tbl.push_back(mk(1,  3, 1,  0, 0, 10, 1, 0, 1, 0, 1, 0, 0, 0, 1)); // flush beats stall
        tbl.push_back(mk(1,  0, 0,  0, 0,  0, 1, 0, 0, 0, 0, 1, 0, 0, 1)); // writes x0
        tbl.push_back(mk(1,  0, 1,  1, 0, 28, 1, 0, 0, 0, 0, 1, 0, 0, 1)); // reads x0
        tbl.push_back(mk(1, 28, 1, 28, 0, 29, 1, 1, 0, 0, 0, 1, 1, 0, 1)); // rs2 unused, lw x29
        tbl.push_back(mk(0, 29, 1,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); // DE empty: no stall

        // Repeated load-use pairs drive the 2-bit counter into saturation.
        c = 1;
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 1, 0, 0, c));
            c = (c < 3) ? c + 1 : 3;
            tbl.push_back(mk(1, 3, 1, 0, 0, 11, 1, 0, 0, 1, 0, 0, 0, 0, c));
            tbl.push_back(mk(1, 3, 1, 0, 0, 11, 1, 0, 0, 0, 0, 1, 2, 0, c));
        end

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Reset in the middle of a stall clears everything without a clock edge.
        apply(mk(1, 0, 0, 0, 0, 28, 1, 0, 0, 0, 0, 1, 0, 0, 3), 100);
        apply(mk(1, 28, 1, 0, 0, 3, 1, 1, 0, 0, 0, 1, 1, 0, 3), 101);
        drive(mk(1, 3, 1, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("pre_rst_stall", 102, int'(stall_if_de), 1);
        RST_N = 1'b0;
        #1;
        chk("async_ex_valid", 102, int'(ex_valid), 0);
        chk("async_sel_a", 102, int'(fwd_sel_a), 0);
        chk("async_count", 102, int'(stall_count), 0);
        chk("async_stall", 102, int'(stall_if_de), 0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        apply(mk(1, 3, 1, 0, 0, 12, 1, 0, 0, 0, 0, 1, 0, 0, 0), 103);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Tracks destination registers of in-flight instructions in the 5-stage pipeline (DE→EX→MEM→WB→WB-hold).
- Generates the 2-bit operand-select codes that drive the ALU-input mux4_1 instances in EX. Codes are computed in DE and registered so they are aligned with the instruction in EX.
- Detects load-use hazards and inserts a 1-cycle bubble. Applies branch-taken flushes.
- Maintains a saturating stall-cycle counter.

Parameters:
- REG_AW, 5, register address width
- CNT_WIDTH, 16, width of stall_count; saturates at all-ones

Ports:
- CLK  input  1  pipeline clock
- RST_N  input  1  asynchronous active-low reset
- de_valid  input  1  valid instruction in DE
- de_rs1  input  REG_AW  source reg 1 of DE instruction
- de_rs2  input  REG_AW  source reg 2 of DE instruction
- de_rs1_used  input  1  DE instruction reads rs1
- de_rs2_used  input  1  DE instruction reads rs2
- de_rd  input  REG_AW  destination of DE instruction
- de_regwrite  input  1  DE instruction writes rd
- de_is_load  input  1  DE instruction is a load
- ex_branch_taken  input  1  EX resolved taken branch/jump
- stall_if_de  output  1  hold PC and IF/DE register (combinational)
- flush_if_de  output  1  squash IF/DE register (combinational)
- ex_valid  output  1  EX holds a live instruction (registered)
- fwd_sel_a  output  2  EX operand-A mux select (registered)
- fwd_sel_b  output  2  EX operand-B mux select (registered)
- stall_count  output  CNT_WIDTH  load-use stall cycles since reset

Behaviour:
- One clock CLK. Reset is asynchronous, active-low (RST_N). All flops clear immediately on RST_N=0.
- Reset values: all stage valid bits 0, fwd_sel_a/b 2'b00, ex_valid 0, stall_count 0. stall_if_de and flush_if_de are 0 while in reset.
- Tracking state: per stage EX, MEM, WB, HOLD holds {valid, rd, regwrite, is_load}. The pipeline advances every cycle: HOLD<=WB, WB<=MEM, MEM<=EX, EX<=DE-or-bubble.
- A stage "writes r" when valid && regwrite && rd==r && r!=0. x0 is never forwarded.
- Select encoding (fwd_sel_t): 00 = register-file value, 01 = EX/MEM ALU result, 10 = MEM/WB writeback data, 11 = WB-hold register.
- Per-operand select, computed in DE for the DE instruction. Only evaluated when rsN_used; otherwise 00.
  - EX stage writes rsN → 01
  - else MEM writes rsN → 10
  - else WB writes rsN → 11
  - else 00
  - The closest producer wins. The distance is measured at the moment the DE instruction enters EX.
- Load-use: load_use = de_valid && EX.valid && EX.is_load && EX stage writes a used rs.
  - When asserted: stall_if_de=1, a bubble enters EX (valid=0, sel 00), and stall_count increments (saturating).
  - On the next cycle the load is in MEM, so the select resolves to 10. A stall therefore lasts exactly 1 cycle.
- Flush: ex_branch_taken=1 → flush_if_de=1, and the EX next state is a bubble.
  - Flush overrides load_use: stall_if_de=0 and no counter increment.
- A bubble in EX forces ex_valid=0 and fwd_sel_a/b=00 on the following edge.
- de_valid=0 → EX receives a bubble; no stall is possible.
- An instruction is never forwarded from itself. A stalled DE instruction re-evaluates its selects every cycle.
- Reset asserted mid-stall or mid-flush clears all state. The first cycle after release behaves like an empty pipeline.

Decomposition:
- Package pipeline_pkg:
  - fwd_sel_t enum {FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10, FWD_HOLD=2'b11}
  - stage_track_t struct {valid, rd, regwrite, is_load}
  - REG_X0 constant
- Sub-module fwd_select: purely combinational. Takes rs, used, and the EX/MEM/WB stage_track_t values; returns fwd_sel_t. Instantiated twice (operand A, operand B).

Test Plan:
- Back-to-back ALU: add x5 (cycle n), then use x5 as rs1 (n+1) → fwd_sel_a=01 while the consumer is in EX; no stall; stall_count=0.
- Distance 2 and 3: producer of x7, one independent instruction, consumer rs2=x7 → fwd_sel_b=10. With two independent instructions between them → 11. With three → 00.
- Load-use: lw x3, then add using x3 as rs1 → stall_if_de=1 for exactly 1 cycle; ex_valid=0 in the bubble cycle; consumer enters EX with fwd_sel_a=10; stall_count=1.
- Flush beats stall: load-use condition with ex_branch_taken=1 in the same cycle → stall_if_de=0, flush_if_de=1, next ex_valid=0, stall_count unchanged.
- x0 and unused source: producer writes x0 and consumer reads x0 → sel 00. Matching rd with rs2_used=0 → fwd_sel_b=00.
- Reset mid-stall: RST_N=0 during the stall cycle → outputs are reset asynchronously (before the next edge): fwd_sel 00, ex_valid 0, stall_count 0. After release, a consumer of the old rd gets sel 00.
